// File: rtl/abram_pkg.sv
// Shared constants and helpers for the ABRAM interconnect request path.
package abram_pkg;

  localparam int ABRAM_ADDR_SIZE = 32;
  localparam int ABRAM_DATA_SIZE = 64;

  // Width needed to index n entries, never less than one bit.
  function automatic int clog2_min1(input int n);
    int r;
    r = $clog2(n);
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/abram_request_fifo.sv
// Per-lane write-request buffer in front of one ABRAM interconnect input.
// First-word fall-through: the oldest request is always driven on ad_*,
// and it is retired when the interconnect pulses ad_done for this lane.
module abram_request_fifo
  import abram_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int ADDR_SIZE = ABRAM_ADDR_SIZE,
  parameter int DATA_SIZE = ABRAM_DATA_SIZE
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   wr_valid,
  input  logic [ADDR_SIZE-1:0]   wr_addr,
  input  logic [DATA_SIZE-1:0]   wr_data,
  output logic                   wr_ready,
  output logic                   ad_valid,
  output logic [ADDR_SIZE-1:0]   ad_addr,
  output logic [DATA_SIZE-1:0]   ad_data,
  input  logic                   ad_done,
  output logic [$clog2(DEPTH):0] count,
  output logic                   spurious_done
);

  localparam int AW = clog2_min1(DEPTH);
  localparam int PW = AW + 1;

  // Extra MSB on each pointer distinguishes full from empty.
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [DEPTH-1:0][ADDR_SIZE-1:0] addr_mem;
  logic [DEPTH-1:0][DATA_SIZE-1:0] data_mem;

  logic empty, full, push, pop;

  // Status purely from registered pointers, so wr_ready never sees ad_done.
  always_comb begin
    empty    = (wr_ptr == rd_ptr);
    full     = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    wr_ready = !full;
    ad_valid = !empty;
    push     = wr_valid && !full;
    pop      = ad_done && !empty;
    count    = wr_ptr - rd_ptr;
    ad_addr  = addr_mem[rd_ptr[AW-1:0]];
    ad_data  = data_mem[rd_ptr[AW-1:0]];
  end

  // Pointer advance and sticky flag for a done with nothing presented.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      spurious_done <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (ad_done && empty) spurious_done <= 1'b1;
    end
  end

  // Storage is left unreset; entries are only visible behind valid pointers.
  always_ff @(posedge clock) begin
    if (push) begin
      addr_mem[wr_ptr[AW-1:0]] <= wr_addr;
      data_mem[wr_ptr[AW-1:0]] <= wr_data;
    end
  end

endmodule

// File: doc/abram_request_fifo.md
Name: abram_request_fifo

Overview:
- Per-requester write-request buffer that sits directly upstream of one input lane of the ABRAM interconnect.
- Absorbs bursts of address/data write requests from a producer (e.g. a relational-cache fetch unit) and presents the oldest request as in_ad_valid/addr/data to the interconnect.
- Retires a request when the interconnect returns in_ad_done for that lane.
- One instance per interconnect input; holds requests while the aging arbiter serves other lanes.

Parameters:
- DEPTH, 4, number of request entries; power of two, >= 2.
- ADDR_SIZE, 32, address width in bits.
- DATA_SIZE, 64, data width in bits.

Ports:
- clock  input  1  single clock; all state rises on posedge.
- reset  input  1  asynchronous, active-low reset.
- wr_valid  input  1  producer offers a request this cycle.
- wr_addr  input  ADDR_SIZE  request address.
- wr_data  input  DATA_SIZE  request data.
- wr_ready  output  1  FIFO accepts the request this cycle.
- ad_valid  output  1  head request present; connects to interconnect in_ad_valid[i].
- ad_addr  output  ADDR_SIZE  head address.
- ad_data  output  DATA_SIZE  head data.
- ad_done  input  1  single-cycle pulse: head request consumed; from interconnect in_ad_done[i].
- count  output  $clog2(DEPTH)+1  number of occupied entries, 0..DEPTH.
- spurious_done  output  1  sticky error flag.

Behaviour:
- Reset (reset=0, asynchronous): wr/rd pointers=0, count=0, ad_valid=0, wr_ready=1, spurious_done=0.
- ad_addr/ad_data are don't-care while ad_valid=0; storage is not reset.
- Pointers are $clog2(DEPTH)+1 bits (extra wrap bit).
  - empty = pointers equal.
  - full = low bits equal and wrap bits differ.
  - Increments wrap modulo 2*DEPTH.
- wr_ready = !full. It is a registered-state function only: no combinational path from ad_done.
- Push: wr_valid && wr_ready. The entry is written at wr_ptr on the clock edge, and wr_ptr increments.
- First-word fall-through:
  - ad_valid = !empty.
  - ad_addr/ad_data = mem[rd_ptr], combinational read of the register array.
  - A request pushed into an empty FIFO appears on ad_valid the next cycle (latency 1).
- Pop: ad_done && ad_valid. rd_ptr increments; the next entry (if any) is presented the following cycle.
- ad_done with ad_valid=0: no pointer change; spurious_done is set to 1 and stays set until reset.
- ad_done held high for N consecutive cycles pops up to N entries, one per cycle. The interconnect contract guarantees a one-cycle pulse per transaction.
- Simultaneous push and pop:
  - Not full: both occur and count is unchanged.
  - Full: wr_ready=0, so the pop only occurs and count becomes DEPTH-1. The push is refused that cycle and the producer retries.
  - Empty: the pop is illegal (spurious_done path) and the push occurs.
- Head stability: while ad_valid=1 and no pop, ad_addr/ad_data must stay constant. This is required by the aging arbiter, which may hold the lane unserved for many cycles.
- Ordering is strictly FIFO; requests are never coalesced or reordered.
- Reset asserted mid-operation discards all entries immediately (ad_valid drops asynchronously). Any in-flight interconnect transaction for this lane is the interconnect's responsibility.
- count = wr_ptr - rd_ptr (unsigned, pointer width).

Decomposition:
- Shared package abram_pkg holds:
  - default constants ABRAM_ADDR_SIZE=32 and ABRAM_DATA_SIZE=64;
  - function clog2_min1 (returns at least 1), used for pointer widths.
- No sub-module; the storage array and pointer logic are small enough for one module.
- The top level instantiates INPUTS copies in front of the interconnect.

Test Plan:
- Reset then idle: after release, ad_valid=0, wr_ready=1, count=0, spurious_done=0 for 10 cycles.
- Push (0x100, 0xA), (0x104, 0xB), (0x108, 0xC) on consecutive cycles.
  - One cycle after the first push: ad_valid=1, ad_addr=0x100, ad_data=0xA.
  - After the pushes: count=3.
  - Three spaced ad_done pulses present 0x104 then 0x108 in order.
  - Final state: ad_valid=0, count=0.
- Fill to DEPTH=4:
  - wr_ready=0 and count=4; a 5th wr_valid is not accepted.
  - Then ad_done with wr_valid high the same cycle: count=3 and the push is refused.
  - Next cycle: push accepted, count=4.
  - Pointer wrap after 3 full cycles: data order is preserved across the wrap.
- Hold a head entry un-acked for 50 cycles: ad_addr/ad_data are stable every cycle; count is unchanged.
- ad_done pulse while empty: spurious_done=1, count stays 0, and the flag remains set after subsequent normal traffic.
- Assert reset mid-stream with count=2: ad_valid=0 and count=0 before the next clock edge. After release, a new push of 0x200 appears as the head, not stale data.
